// File: rtl/input_vector_loader.sv
// input_vector_loader: assembles a pixel stream into a flat frame vector and strobes the first-layer latch
module input_vector_loader #(
    parameter int weightNo  = 784,
    parameter int dataWidth = 16,
    localparam int CW       = $clog2(weightNo)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          s_valid,
    input  logic [dataWidth-1:0]          s_data,
    input  logic                          s_last,
    output logic                          s_ready,
    input  logic                          net_ready,
    output logic [weightNo*dataWidth-1:0] vec_out,
    output logic                          load_pulse,
    output logic                          err_len,
    output logic [15:0]                   frame_count,
    output logic [CW-1:0]                 pix_idx
);
    typedef enum logic [1:0] {FILL, WAIT, ISSUE} state_t;
    localparam logic [CW-1:0] LAST = CW'(weightNo - 1);
    state_t state;
    assign s_ready = (state == FILL);
    // frame assembly, hand-off to the network and framing-error detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            pix_idx     <= '0;
            vec_out     <= '0;
            load_pulse  <= 1'b0;
            err_len     <= 1'b0;
            frame_count <= '0;
        end else begin
            load_pulse <= 1'b0;
            err_len    <= 1'b0;
            case (state)
                FILL: if (s_valid) begin
                    vec_out[pix_idx*dataWidth +: dataWidth] <= s_data;
                    if (pix_idx == LAST) begin
                        pix_idx <= '0;
                        if (s_last) state <= WAIT;
                        else err_len <= 1'b1;
                    end else if (s_last) begin
                        pix_idx <= '0;
                        err_len <= 1'b1;
                    end else begin
                        pix_idx <= pix_idx + 1'b1;
                    end
                end
                WAIT: if (net_ready) begin
                    state      <= ISSUE;
                    load_pulse <= 1'b1;
                end
                ISSUE: begin
                    state       <= FILL;
                    frame_count <= frame_count + 16'd1;
                end
                default: state <= FILL;
            endcase
        end
    end
endmodule

// File: doc/input_vector_loader.md
Name: input_vector_loader

Overview:
- Producer side of the first-layer input latch. Accepts one pixel per handshake on a streaming interface and assembles weightNo pixels into a flat vector.
- When a full frame is present and the network is ready, it emits a single-cycle load pulse; this pulse drives the latch's first/done_in input.
- Vector contents are held stable on the load cycle, so the latch captures a complete, consistent frame.
- Sits between the pixel source (UART/DMA/testbench stream) and the first layer.

Parameters:
- weightNo, 784, pixels per frame (vector length).
- dataWidth, 16, bits per pixel.
- CW, $clog2(weightNo), pixel index counter width (derived, not overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  pixel valid.
- s_data  in  dataWidth  pixel value.
- s_last  in  1  marks final pixel of a frame.
- s_ready  out  1  loader can accept a pixel.
- net_ready  in  1  network can take a new frame (tie to downstream done_in, or to 1 for free-run).
- vec_out  out  weightNo*dataWidth  assembled vector; pixel i occupies bits [i*dataWidth +: dataWidth].
- load_pulse  out  1  one-cycle strobe to the latch's first/done_in input.
- err_len  out  1  one-cycle strobe on a framing error.
- frame_count  out  16  count of issued frames, wraps at 65535→0.
- pix_idx  out  CW  index of the next pixel to be written.

Behaviour:
- Reset (asynchronous, rst_n=0): state=FILL, pix_idx=0, vec_out=0, load_pulse=0, err_len=0, frame_count=0.
- s_ready is decoded from registered state and equals (state==FILL). It is high in the first cycle after reset release.
- States:
  - FILL: accepting pixels.
  - WAIT: frame complete; waiting for net_ready.
  - ISSUE: load_pulse=1 for exactly this one cycle.
- FILL, on accept (s_valid & s_ready):
  - Write s_data into slot pix_idx at the clock edge.
  - If pix_idx<weightNo-1 and s_last=0: pix_idx+1.
  - If pix_idx==weightNo-1 and s_last=1: pix_idx←0, go to WAIT.
  - If s_last=1 and pix_idx<weightNo-1 (short frame): err_len=1 next cycle, pix_idx←0, stay in FILL, no load.
  - If pix_idx==weightNo-1 and s_last=0 (long frame): err_len=1, pix_idx←0, stay in FILL, no load. The next pixel starts a new frame.
  - On error, previously written slots are not cleared; they are overwritten by the next frame.
- FILL with no accept: hold all state.
- WAIT:
  - s_ready=0; vec_out frozen.
  - If net_ready=1 → ISSUE next cycle, else stay.
  - net_ready already high on entry gives a minimum latency of 2 cycles: last accept → load_pulse.
- ISSUE:
  - load_pulse=1 and vec_out unchanged during this cycle, so the latch samples a stable vector at this edge.
  - frame_count+1 at the exit edge; → FILL.
  - s_ready=0 during ISSUE. First pixel of the next frame is accepted at the earliest one cycle after load_pulse.
- load_pulse and err_len are registered and never high in the same cycle. Neither is ever high for two consecutive cycles from the same event.
- vec_out is never modified in WAIT or ISSUE.
- Throughput: weightNo+2 cycles per frame minimum, with s_valid held high and net_ready=1.
- Reset asserted mid-frame or mid-WAIT/ISSUE: immediate return to the reset values; a partial frame is discarded and no load_pulse is emitted.
- pix_idx never exceeds weightNo-1.

Test Plan:
- weightNo=4, dataWidth=16, net_ready=1; stream 0x0001,0x0002,0x0003,0x0004 with s_last on the 4th → vec_out=0x0004_0003_0002_0001; load_pulse high exactly once, 2 cycles after the 4th accept; frame_count=1.
- Same frame, net_ready=0 for 5 cycles, then 1 → s_ready=0 and vec_out stable throughout WAIT; load_pulse exactly 1 cycle after net_ready rises; a pixel offered during WAIT is not accepted.
- Short frame: 2 pixels, s_last on the 2nd → err_len one-cycle pulse, no load_pulse, pix_idx=0; a following valid 4-pixel frame loads correctly and frame_count=1.
- Long frame: 4 pixels, none with s_last → err_len on the 4th, no load; the 5th pixel lands in slot 0.
- s_valid toggling randomly (50%) across 3 back-to-back frames → exactly 3 load_pulses, each vec_out matching its frame; frame_count=3.
- rst_n low after 2 of 4 pixels → all outputs reset; the next full frame loads with no stale pulse. Default params (784×16): one sequential ramp frame 0..783 → slot i = i, load at cycle 786.
